arbitro_escrita_reg: RTL and testbench
======================================

Name: arbitro_escrita_reg

Overview:
Arbitrates the single write port of banco_registradores between two writeback sources: the ALU result path and the memory-load path. Each source has a small request queue with a valid/ready handshake. Granted writes drive esc_reg, reg_a_ser_escrito and dado_de_escrita straight from flops, so the level-sensitive bank sees no glitches. A pending-write scoreboard tells the decode stage whether a register it is about to read still has a queued write.

Parameters:
LARGURA_DADO, 32, data width of write requests and bank data.
LARGURA_END, 5, register index width (32 registers).
PROFUNDIDADE, 2, entries per source queue (power of two, >=2).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_alu_valido  in  1  ALU write request valid
req_alu_reg  in  LARGURA_END  ALU destination register
req_alu_dado  in  LARGURA_DADO  ALU write data
req_alu_pronto  out  1  ALU queue can accept (not full)
req_mem_valido  in  1  load write request valid
req_mem_reg  in  LARGURA_END  load destination register
req_mem_dado  in  LARGURA_DADO  load write data
req_mem_pronto  out  1  load queue can accept (not full)
esc_reg  out  1  write enable to bank (registered)
reg_a_ser_escrito  out  LARGURA_END  write index to bank (registered)
dado_de_escrita  out  LARGURA_DADO  write data to bank (registered)
consulta_reg_a  in  LARGURA_END  register about to be read, port A
consulta_reg_b  in  LARGURA_END  register about to be read, port B
pendente_a  out  1  queued or in-flight write targets consulta_reg_a
pendente_b  out  1  queued or in-flight write targets consulta_reg_b
ocupado  out  1  any queue non-empty or esc_reg high

Behaviour:
- Reset (reset=0, async): both queues emptied; esc_reg=0, reg_a_ser_escrito=0, dado_de_escrita=0; priority pointer set to ALU; FSM to OCIOSO. All queued entries are discarded. After reset: pronto outputs=1, pendente_*=0, ocupado=0.
- Handshake: a transfer occurs at a rising edge when valido=1 and pronto=1. pronto = queue not full and depends only on current occupancy; a full queue keeps pronto=0 even in a cycle where it pops. When pronto=0, requesters hold valido, reg and dado stable.
- Writes to register 0 complete the handshake but are dropped. They are never enqueued, never issued and never flagged pending.
- Queues are FIFO per source. Each source's write order is preserved. Order between sources is not guaranteed; upstream uses pendente_* to avoid write-after-write conflicts.
- Arbitration is combinational on the queue heads.
  - Only one queue non-empty: that queue is granted.
  - Both non-empty: the source named by the pointer is granted, and the pointer then moves to the other source (round-robin).
  - Pointer changes only on a grant with contention; an uncontended grant leaves it unchanged.
- FSM:
  - OCIOSO: esc_reg=0. Go to ESCREVENDO on any grant.
  - ESCREVENDO: esc_reg=1. Stay on a new grant (back-to-back; reg_a_ser_escrito and dado_de_escrita update together at the edge). Go to OCIOSO when no grant.
  - In OCIOSO, reg_a_ser_escrito and dado_de_escrita hold their last values.
- Latency: request accepted at edge N into an empty system gives esc_reg=1 from edge N+1, for exactly one cycle per write. Throughput is one write per cycle.
- Simultaneous push and pop on the same queue in one cycle are legal (queue not full): occupancy is unchanged.
- pendente_x = (consulta_reg_x != 0) and (x matches any valid entry in either queue, or esc_reg=1 and reg_a_ser_escrito matches). Combinational; a request being accepted in the current cycle is not yet visible.
- Pointer wrap: read and write pointers wrap modulo PROFUNDIDADE; full/empty are distinguished by an extra pointer bit or a count.

Test Plan:
- Reset then idle: release reset, no requests -> esc_reg=0, both pronto=1, ocupado=0, pendente_a=pendente_b=0 for 10 cycles.
- Single write: ALU pushes reg=5, dado=0x0000_00AA at edge N -> at edge N+1 esc_reg=1, reg_a_ser_escrito=5, dado_de_escrita=0xAA for one cycle; pendente_a=1 for consulta_reg_a=5 during cycles N..N+1, then 0.
- Contention: both sources push every cycle (ALU regs 1,2,3; MEM regs 11,12,13) -> bank sees 1,11,2,12,3,13 back-to-back with esc_reg held high for 6 cycles.
- Backpressure: MEM pushes 3 writes while arbitration is blocked by a steady ALU stream -> req_mem_pronto=0 once 2 entries are queued, the third transfer waits, and no entry is lost or duplicated.
- Register 0: ALU pushes reg=0, dado=0xFFFF_FFFF -> handshake completes, esc_reg stays 0, pendente_a=0 with consulta_reg_a=0.
- Reset mid-operation: with 2 entries in each queue, pull reset low for one cycle -> esc_reg=0 immediately (async), ocupado=0; after release no stale writes are issued.

Source files
------------

// File: rtl/arbitro_escrita_reg.sv
// Write-port arbiter for banco_registradores: two per-source request queues
// (ALU result, memory load), round-robin grant, registered bank outputs and a pending-write scoreboard.

module fila_escrita #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 5,
  parameter int PROFUNDIDADE = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [LARGURA_END-1:0]  push_reg,
  input  logic [LARGURA_DADO-1:0] push_dado,
  input  logic                    pop,
  output logic                    vazia,
  output logic                    cheia,
  output logic [LARGURA_END-1:0]  cab_reg,
  output logic [LARGURA_DADO-1:0] cab_dado,
  input  logic [LARGURA_END-1:0]  consulta_a,
  input  logic [LARGURA_END-1:0]  consulta_b,
  output logic                    acerto_a,
  output logic                    acerto_b
);

  localparam int LARGURA_PTR = $clog2(PROFUNDIDADE);

  // The extra MSB on each pointer separates full from empty when the indices coincide.
  logic [LARGURA_PTR:0]    ptr_esc;
  logic [LARGURA_PTR:0]    ptr_lei;
  logic [LARGURA_PTR-1:0]  idx_esc;
  logic [LARGURA_PTR-1:0]  idx_lei;
  logic [PROFUNDIDADE-1:0] ocupada;
  logic [LARGURA_END-1:0]  mem_reg  [PROFUNDIDADE];
  logic [LARGURA_DADO-1:0] mem_dado [PROFUNDIDADE];

  assign idx_esc = ptr_esc[LARGURA_PTR-1:0];
  assign idx_lei = ptr_lei[LARGURA_PTR-1:0];
  assign vazia   = (ptr_esc == ptr_lei);
  assign cheia   = (ptr_esc[LARGURA_PTR] != ptr_lei[LARGURA_PTR]) && (idx_esc == idx_lei);
  assign cab_reg  = mem_reg[idx_lei];
  assign cab_dado = mem_dado[idx_lei];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_esc <= '0;
      ptr_lei <= '0;
      ocupada <= '0;
    end else begin
      // Push and pop never hit the same slot: that needs an empty pop or a full push.
      if (push) begin
        ptr_esc          <= ptr_esc + (LARGURA_PTR+1)'(1);
        ocupada[idx_esc] <= 1'b1;
      end
      if (pop) begin
        ptr_lei          <= ptr_lei + (LARGURA_PTR+1)'(1);
        ocupada[idx_lei] <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; the ocupada bits alone decide which slots are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[idx_esc]  <= push_reg;
      mem_dado[idx_esc] <= push_dado;
    end
  end

  // NOTE: outputs get a default before the loop so no latch is inferred.
  always_comb begin
    acerto_a = 1'b0;
    acerto_b = 1'b0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      if (ocupada[i] && (mem_reg[i] == consulta_a)) acerto_a = 1'b1;
      if (ocupada[i] && (mem_reg[i] == consulta_b)) acerto_b = 1'b1;
    end
  end

endmodule

module arbitro_escrita_reg #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 5,
  parameter int PROFUNDIDADE = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_alu_valido,
  input  logic [LARGURA_END-1:0]  req_alu_reg,
  input  logic [LARGURA_DADO-1:0] req_alu_dado,
  output logic                    req_alu_pronto,
  input  logic                    req_mem_valido,
  input  logic [LARGURA_END-1:0]  req_mem_reg,
  input  logic [LARGURA_DADO-1:0] req_mem_dado,
  output logic                    req_mem_pronto,
  output logic                    esc_reg,
  output logic [LARGURA_END-1:0]  reg_a_ser_escrito,
  output logic [LARGURA_DADO-1:0] dado_de_escrita,
  input  logic [LARGURA_END-1:0]  consulta_reg_a,
  input  logic [LARGURA_END-1:0]  consulta_reg_b,
  output logic                    pendente_a,
  output logic                    pendente_b,
  output logic                    ocupado
);

  typedef enum logic {OCIOSO, ESCREVENDO} estado_t;
  typedef enum logic {PRIO_ALU, PRIO_MEM} prio_t;

  estado_t estado, estado_prox;
  prio_t   prio, prio_prox;

  logic                    alu_push, alu_vazia, alu_cheia, alu_acerto_a, alu_acerto_b;
  logic                    mem_push, mem_vazia, mem_cheia, mem_acerto_a, mem_acerto_b;
  logic [LARGURA_END-1:0]  alu_cab_reg, mem_cab_reg;
  logic [LARGURA_DADO-1:0] alu_cab_dado, mem_cab_dado;
  logic                    alu_tem, mem_tem, concede_alu, concede_mem, concede;

  // Writes to register 0 finish the handshake but are discarded here.
  assign req_alu_pronto = !alu_cheia;
  assign req_mem_pronto = !mem_cheia;
  assign alu_push = req_alu_valido && req_alu_pronto && (req_alu_reg != '0);
  assign mem_push = req_mem_valido && req_mem_pronto && (req_mem_reg != '0);

  fila_escrita #(
    .LARGURA_DADO(LARGURA_DADO),
    .LARGURA_END (LARGURA_END),
    .PROFUNDIDADE(PROFUNDIDADE)
  ) u_fila_alu (
    .clock     (clock),
    .reset     (reset),
    .push      (alu_push),
    .push_reg  (req_alu_reg),
    .push_dado (req_alu_dado),
    .pop       (concede_alu),
    .vazia     (alu_vazia),
    .cheia     (alu_cheia),
    .cab_reg   (alu_cab_reg),
    .cab_dado  (alu_cab_dado),
    .consulta_a(consulta_reg_a),
    .consulta_b(consulta_reg_b),
    .acerto_a  (alu_acerto_a),
    .acerto_b  (alu_acerto_b)
  );

  fila_escrita #(
    .LARGURA_DADO(LARGURA_DADO),
    .LARGURA_END (LARGURA_END),
    .PROFUNDIDADE(PROFUNDIDADE)
  ) u_fila_mem (
    .clock     (clock),
    .reset     (reset),
    .push      (mem_push),
    .push_reg  (req_mem_reg),
    .push_dado (req_mem_dado),
    .pop       (concede_mem),
    .vazia     (mem_vazia),
    .cheia     (mem_cheia),
    .cab_reg   (mem_cab_reg),
    .cab_dado  (mem_cab_dado),
    .consulta_a(consulta_reg_a),
    .consulta_b(consulta_reg_b),
    .acerto_a  (mem_acerto_a),
    .acerto_b  (mem_acerto_b)
  );

  // The pointer only breaks ties; a lone non-empty queue always wins.
  assign alu_tem     = !alu_vazia;
  assign mem_tem     = !mem_vazia;
  assign concede_alu = alu_tem && (!mem_tem || (prio == PRIO_ALU));
  assign concede_mem = mem_tem && (!alu_tem || (prio == PRIO_MEM));
  assign concede     = concede_alu || concede_mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      prio   <= PRIO_ALU;
    end else begin
      estado <= estado_prox;
      prio   <= prio_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    prio_prox   = prio;
    case (estado)
      OCIOSO:     if (concede)  estado_prox = ESCREVENDO;
      ESCREVENDO: if (!concede) estado_prox = OCIOSO;
      default:    estado_prox = OCIOSO;
    endcase
    if (alu_tem && mem_tem) prio_prox = concede_alu ? PRIO_MEM : PRIO_ALU;
  end

  // Index and data load together with the grant and otherwise hold, so the bank never sees a mix.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_a_ser_escrito <= '0;
      dado_de_escrita   <= '0;
    end else if (concede) begin
      reg_a_ser_escrito <= concede_alu ? alu_cab_reg  : mem_cab_reg;
      dado_de_escrita   <= concede_alu ? alu_cab_dado : mem_cab_dado;
    end
  end

  assign esc_reg = (estado == ESCREVENDO);

  assign pendente_a = (consulta_reg_a != '0) &&
                      (alu_acerto_a || mem_acerto_a || (esc_reg && (reg_a_ser_escrito == consulta_reg_a)));
  assign pendente_b = (consulta_reg_b != '0) &&
                      (alu_acerto_b || mem_acerto_b || (esc_reg && (reg_a_ser_escrito == consulta_reg_b)));

  assign ocupado = alu_tem || mem_tem || esc_reg;

endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// Directed bench for arbitro_escrita_reg: per-source scoreboards fed at acceptance,
// drained by a negedge monitor on the bank write port.

module tb_arbitro_escrita_reg;

  localparam int LD = 32;
  localparam int LE = 5;

  typedef struct {
    logic [LE-1:0] r;
    logic [LD-1:0] d;
  } req_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_alu_valido = 1'b0;
  logic [LE-1:0] req_alu_reg = '0;
  logic [LD-1:0] req_alu_dado = '0;
  logic          req_alu_pronto;
  logic          req_mem_valido = 1'b0;
  logic [LE-1:0] req_mem_reg = '0;
  logic [LD-1:0] req_mem_dado = '0;
  logic          req_mem_pronto;
  logic          esc_reg;
  logic [LE-1:0] reg_a_ser_escrito;
  logic [LD-1:0] dado_de_escrita;
  logic [LE-1:0] consulta_reg_a = '0;
  logic [LE-1:0] consulta_reg_b = '0;
  logic          pendente_a;
  logic          pendente_b;
  logic          ocupado;

  arbitro_escrita_reg #(
    .LARGURA_DADO(LD),
    .LARGURA_END (LE),
    .PROFUNDIDADE(2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_alu_valido   (req_alu_valido),
    .req_alu_reg      (req_alu_reg),
    .req_alu_dado     (req_alu_dado),
    .req_alu_pronto   (req_alu_pronto),
    .req_mem_valido   (req_mem_valido),
    .req_mem_reg      (req_mem_reg),
    .req_mem_dado     (req_mem_dado),
    .req_mem_pronto   (req_mem_pronto),
    .esc_reg          (esc_reg),
    .reg_a_ser_escrito(reg_a_ser_escrito),
    .dado_de_escrita  (dado_de_escrita),
    .consulta_reg_a   (consulta_reg_a),
    .consulta_reg_b   (consulta_reg_b),
    .pendente_a       (pendente_a),
    .pendente_b       (pendente_b),
    .ocupado          (ocupado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  req_t pend_alu[$], pend_mem[$];
  req_t exp_alu[$], exp_mem[$];
  logic [LE-1:0] visto[$];
  int stall_mem = 0;
  int run_len = 0;
  int max_run = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // Presents queued requests, holding each until accepted; accepted non-zero
  // writes go onto that source's scoreboard.
  task automatic executa(input int max_ciclos);
    bit ac_a, ac_m;
    int n;
    req_t t;
    n = 0;
    while ((pend_alu.size() > 0 || pend_mem.size() > 0) && n < max_ciclos) begin
      req_alu_valido = (pend_alu.size() > 0);
      if (pend_alu.size() > 0) begin
        req_alu_reg  = pend_alu[0].r;
        req_alu_dado = pend_alu[0].d;
      end
      req_mem_valido = (pend_mem.size() > 0);
      if (pend_mem.size() > 0) begin
        req_mem_reg  = pend_mem[0].r;
        req_mem_dado = pend_mem[0].d;
      end
      #1;
      ac_a = req_alu_valido && req_alu_pronto;
      ac_m = req_mem_valido && req_mem_pronto;
      if (req_mem_valido && !req_mem_pronto) stall_mem++;
      ciclo();
      if (ac_a) begin
        t = pend_alu.pop_front();
        if (t.r != '0) exp_alu.push_back(t);
      end
      if (ac_m) begin
        t = pend_mem.pop_front();
        if (t.r != '0) exp_mem.push_back(t);
      end
      n++;
    end
    req_alu_valido = 1'b0;
    req_mem_valido = 1'b0;
    check("handshake_budget", 64'(pend_alu.size() + pend_mem.size()), 64'd0);
  endtask

  task automatic drena(input string tag);
    int n;
    n = 0;
    while ((exp_alu.size() > 0 || exp_mem.size() > 0 || ocupado !== 1'b0) && n < 40) begin
      ciclo();
      n++;
    end
    check({tag, "_entregues"}, 64'(exp_alu.size() + exp_mem.size()), 64'd0);
    check({tag, "_ocupado"}, 64'(ocupado), 64'd0);
  endtask

  // Bank-side monitor: every issued write must be the head of one source's scoreboard.
  always @(negedge clock) begin
    if (esc_reg === 1'b1) begin
      visto.push_back(reg_a_ser_escrito);
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_alu.size() > 0 && exp_alu[0].r === reg_a_ser_escrito) begin
        check("dado_alu", 64'(dado_de_escrita), 64'(exp_alu[0].d));
        void'(exp_alu.pop_front());
      end else if (exp_mem.size() > 0 && exp_mem[0].r === reg_a_ser_escrito) begin
        check("dado_mem", 64'(dado_de_escrita), 64'(exp_mem[0].d));
        void'(exp_mem.pop_front());
      end else begin
        check("escrita_inesperada", 64'(esc_reg), 64'd0);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LE-1:0] ordem [6];
    req_t t;
    ordem = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};

    // Reset then idle
    repeat (2) @(posedge clock);
    #1;
    check("reset_esc", 64'(esc_reg), 64'd0);
    check("reset_reg", 64'(reg_a_ser_escrito), 64'd0);
    check("reset_dado", 64'(dado_de_escrita), 64'd0);
    reset = 1'b1;
    consulta_reg_b = 5'd3;
    for (int i = 0; i < 10; i++) begin
      ciclo();
      check("idle_esc", 64'(esc_reg), 64'd0);
      check("idle_pronto_alu", 64'(req_alu_pronto), 64'd1);
      check("idle_pronto_mem", 64'(req_mem_pronto), 64'd1);
      check("idle_ocupado", 64'(ocupado), 64'd0);
      check("idle_pend_a", 64'(pendente_a), 64'd0);
      check("idle_pend_b", 64'(pendente_b), 64'd0);
    end

    // Single write: accepted at edge N, on the bank for exactly cycle N+1
    consulta_reg_a = 5'd5;
    consulta_reg_b = 5'd0;
    req_alu_valido = 1'b1;
    req_alu_reg    = 5'd5;
    req_alu_dado   = 32'h0000_00AA;
    #1;
    check("single_pronto", 64'(req_alu_pronto), 64'd1);
    check("single_pend_antes", 64'(pendente_a), 64'd0);
    ciclo();
    t.r = 5'd5;
    t.d = 32'h0000_00AA;
    exp_alu.push_back(t);
    req_alu_valido = 1'b0;
    #1;
    check("single_pend_n", 64'(pendente_a), 64'd1);
    check("single_esc_n", 64'(esc_reg), 64'd0);
    check("single_ocupado_n", 64'(ocupado), 64'd1);
    check("single_pend_b_zero", 64'(pendente_b), 64'd0);
    ciclo();
    check("single_esc_n1", 64'(esc_reg), 64'd1);
    check("single_reg_n1", 64'(reg_a_ser_escrito), 64'd5);
    check("single_dado_n1", 64'(dado_de_escrita), 64'h0000_00AA);
    check("single_pend_n1", 64'(pendente_a), 64'd1);
    ciclo();
    check("single_esc_n2", 64'(esc_reg), 64'd0);
    check("single_pend_n2", 64'(pendente_a), 64'd0);
    check("single_reg_hold", 64'(reg_a_ser_escrito), 64'd5);
    drena("single");

    // Register 0: handshake completes, nothing issued or flagged
    consulta_reg_a = 5'd0;
    req_alu_valido = 1'b1;
    req_alu_reg    = 5'd0;
    req_alu_dado   = 32'hFFFF_FFFF;
    #1;
    check("r0_pronto", 64'(req_alu_pronto), 64'd1);
    ciclo();
    req_alu_valido = 1'b0;
    #1;
    check("r0_ocupado", 64'(ocupado), 64'd0);
    check("r0_pend_a", 64'(pendente_a), 64'd0);
    ciclo();
    check("r0_esc", 64'(esc_reg), 64'd0);
    check("r0_pronto_depois", 64'(req_alu_pronto), 64'd1);

    // Backpressure: MEM fills to 2 while competing with a steady ALU stream
    for (int i = 0; i < 4; i++) begin
      t.r = LE'(20 + i);
      t.d = 32'h0000_0300 + 32'(i);
      pend_alu.push_back(t);
    end
    for (int i = 0; i < 3; i++) begin
      t.r = LE'(7 + i);
      t.d = 32'h0000_0400 + 32'(i);
      pend_mem.push_back(t);
    end
    stall_mem = 0;
    executa(20);
    check("bp_mem_pronto_baixo", 64'(stall_mem > 0), 64'd1);
    drena("bp");

    // Contention: strict alternation starting from the ALU
    for (int i = 0; i < 3; i++) begin
      t.r = LE'(1 + i);
      t.d = 32'h0000_0101 + 32'(i);
      pend_alu.push_back(t);
      t.r = LE'(11 + i);
      t.d = 32'h0000_0211 + 32'(i);
      pend_mem.push_back(t);
    end
    visto.delete();
    max_run = 0;
    executa(20);
    drena("cont");
    check("cont_n_escritas", 64'(visto.size()), 64'd6);
    check("cont_rajada", 64'(max_run), 64'd6);
    for (int i = 0; i < 6; i++)
      check("cont_ordem", 64'((i < visto.size()) ? visto[i] : 5'h1f), 64'(ordem[i]));

    // Reset mid-operation
    for (int i = 0; i < 2; i++) begin
      t.r = LE'(21 + i);
      t.d = 32'h0000_0500 + 32'(i);
      pend_alu.push_back(t);
      t.r = LE'(24 + i);
      t.d = 32'h0000_0600 + 32'(i);
      pend_mem.push_back(t);
    end
    executa(10);
    consulta_reg_a = 5'd22;
    consulta_reg_b = 5'd25;
    #1;
    check("mid_esc_antes", 64'(esc_reg), 64'd1);
    check("mid_pend_a_antes", 64'(pendente_a), 64'd1);
    check("mid_pend_b_antes", 64'(pendente_b), 64'd1);
    reset = 1'b0;
    #1;
    exp_alu.delete();
    exp_mem.delete();
    check("mid_esc_async", 64'(esc_reg), 64'd0);
    check("mid_ocupado", 64'(ocupado), 64'd0);
    check("mid_pend_a", 64'(pendente_a), 64'd0);
    check("mid_pend_b", 64'(pendente_b), 64'd0);
    check("mid_pronto_alu", 64'(req_alu_pronto), 64'd1);
    check("mid_pronto_mem", 64'(req_mem_pronto), 64'd1);
    check("mid_reg_zero", 64'(reg_a_ser_escrito), 64'd0);
    ciclo();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ciclo();
      check("mid_sem_escrita", 64'(esc_reg), 64'd0);
      check("mid_ocupado_depois", 64'(ocupado), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
